// File: rtl/binary_counter_param.sv
// Parametrised up/down counter with programmable modulus, run-time step, parallel load,
// wrap/saturate selection, optional edge-qualified requests and registered status flags.
module binary_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 2**WIDTH-1,
    parameter int EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             increment,
    input  logic             decrement,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] step,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] LP_MOD = LP_MAX + 1'b1;

    logic [WIDTH-1:0] r_count;
    logic             r_at_max;
    logic             r_at_zero;
    logic             r_ovf;
    logic             r_unf;

    logic             w_up;
    logic             w_dn;
    logic [WIDTH:0]   w_cnt;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_ld;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_next;
    logic             w_ovf;
    logic             w_unf;

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic r_inc_q;
            logic r_dec_q;
            // History is tracked regardless of enable so a held request never re-fires.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_inc_q <= 1'b0;
                    r_dec_q <= 1'b0;
                end else begin
                    r_inc_q <= increment;
                    r_dec_q <= decrement;
                end
            end
            assign w_up = increment & ~r_inc_q;
            assign w_dn = decrement & ~r_dec_q;
        end else begin : g_level
            assign w_up = increment;
            assign w_dn = decrement;
        end
    endgenerate

    assign w_cnt  = {1'b0, r_count};
    assign w_step = ({1'b0, step} > LP_MAX) ? LP_MAX : {1'b0, step};
    assign w_ld   = ({1'b0, load_value} > LP_MAX) ? LP_MAX : {1'b0, load_value};
    assign w_sum  = w_cnt + w_step;

    always_comb begin
        w_next = w_cnt;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if (load) begin
            w_next = w_ld;
        end else if (enable && (w_up ^ w_dn)) begin
            if (w_up) begin
                if (w_sum > LP_MAX) begin
                    w_ovf  = 1'b1;
                    w_next = sat_mode ? LP_MAX : (w_sum - LP_MOD);
                end else begin
                    w_next = w_sum;
                end
            end else begin
                if (w_step > w_cnt) begin
                    w_unf  = 1'b1;
                    w_next = sat_mode ? '0 : (w_cnt + LP_MOD - w_step);
                end else begin
                    w_next = w_cnt - w_step;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count   <= '0;
            r_at_max  <= (LP_MAX == '0);
            r_at_zero <= 1'b1;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_count   <= w_next[WIDTH-1:0];
            r_at_max  <= (w_next == LP_MAX);
            r_at_zero <= (w_next == '0);
            r_ovf     <= w_ovf;
            r_unf     <= w_unf;
        end
    end

    assign count     = r_count;
    assign at_max    = r_at_max;
    assign at_zero   = r_at_zero;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: doc/binary_counter_param.md
Name: binary_counter_param

Overview:
Parametrised successor to the team's 4-bit increment counter. Adds generic width, programmable modulus, up/down stepping by a run-time step size, and parallel load. It also adds wrap or saturate mode, optional edge-qualified requests, and status/event flags. Used as the general-purpose event/tick counter in sequential-circuit designs.

Parameters:
WIDTH, 4, counter bit width (≥2).
MAX_VAL, 2**WIDTH-1, terminal count; counter range is 0..MAX_VAL (MAX_VAL ≤ 2**WIDTH-1).
EDGE_MODE, 0, 0 = increment/decrement act every cycle they are high; 1 = act only on their 0→1 transition.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block).
enable  input  1  global count enable; load is NOT gated by enable.
increment  input  1  count-up request.
decrement  input  1  count-down request.
load  input  1  parallel load strobe.
load_value  input  WIDTH  value to load.
step  input  WIDTH  amount added/subtracted per accepted request.
sat_mode  input  1  0 = wrap modulo MAX_VAL+1; 1 = saturate at 0/MAX_VAL.
count  output  WIDTH  registered counter value.
at_max  output  1  registered, count==MAX_VAL.
at_zero  output  1  registered, count==0.
overflow  output  1  one-cycle pulse: the up-step crossed MAX_VAL.
underflow  output  1  one-cycle pulse: the down-step crossed 0.

Behaviour:
- Reset (reset==0 at edge):
  - count=0, at_zero=1, at_max=0 (at_max=1 only if MAX_VAL==0, disallowed), overflow=0, underflow=0.
  - Edge-detect history registers cleared to 0, so a request held high through reset release counts once in EDGE_MODE=1.
- Reset overrides everything, including mid-load and mid-request.
- All outputs are registered. An accepted request is visible on count one cycle after the edge that samples it.
- Request qualification:
  - EDGE_MODE=0: up_req=increment, dn_req=decrement.
  - EDGE_MODE=1: up_req=increment & ~increment_q, and likewise for decrement. The _q history registers update every cycle regardless of enable.
- Priority per cycle: load > (up_req XOR dn_req, with enable=1) > hold.
  - up_req & dn_req together → hold, no flags.
  - enable=0 → hold, no flags (load still works).
- Load: count ← min(load_value, MAX_VAL). No overflow/underflow pulse.
- Arithmetic is done in WIDTH+1 bits; no truncation before the compare.
- Up:
  - sum=count+step.
  - If sum>MAX_VAL: overflow=1; count ← sum-(MAX_VAL+1) when wrapping, or MAX_VAL when saturating.
  - Otherwise count ← sum.
- Down:
  - If step>count: underflow=1; count ← count+(MAX_VAL+1)-step when wrapping, or 0 when saturating.
  - Otherwise count ← count-step.
- step=0: count unchanged, no flags.
- step>MAX_VAL is illegal. The implementation clamps step to MAX_VAL internally.
- Saturate at limit: up at MAX_VAL or down at 0 still pulses overflow/underflow; count is unchanged.
- overflow/underflow:
  - High for exactly the one cycle following the causing edge.
  - Never both high.
  - Cleared on any cycle with no crossing.
- at_max/at_zero always track the registered count; they also update after a load.

Test Plan:
- Reset and hold: reset=0 for 2 cycles with increment=1 → count=0, at_zero=1, no flags; release with enable=0 → count stays 0.
- Wrap up (WIDTH=4, MAX_VAL=9, step=1, sat_mode=0): 10 increment cycles from 0 → count 1..9, then 0; overflow pulses exactly on the 9→0 cycle; at_max=1 while count=9.
- Step and down wrap (MAX_VAL=15, step=3): load 14, one up → count=1 with overflow; then one down → count=14 with underflow.
- Saturate (MAX_VAL=9, sat_mode=1, step=4): load 8, up → 9 with overflow; up again → 9 with overflow; load 2, down → 0 with underflow.
- Priority: load=1, load_value=12, increment=1, decrement=1 at MAX_VAL=9 → count=9, no flags; then increment=decrement=1 → hold; then enable=0 with increment=1 → hold.
- EDGE_MODE=1: increment held high 5 cycles → count +1 once; toggled 0/1 three times → +3. Mid-count reset with increment high → count=0, and the first post-reset cycle counts once.
